// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential, taken branch or J-type jump.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] id_pc4,
    input  logic        id_valid,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc,
    output pc_sel_e     pc_sel
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_branch_pc;
    logic [31:0] w_jump_pc;

    assign w_seq_pc    = pc + PC_STEP;
    // Word offset sign-extended and scaled to bytes in a single concatenation.
    assign w_branch_pc = id_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_jump_pc   = {id_pc4[31:28], jump_index, 2'b00};

    always_comb begin
        pc_sel  = PC_SEQ;
        next_pc = w_seq_pc;
        if (id_valid && jump) begin
            pc_sel  = PC_JUMP;
            next_pc = w_jump_pc;
        end else if (id_valid && branch_taken) begin
            pc_sel  = PC_BRANCH;
            next_pc = w_branch_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and fetch counter.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_next_pc;
    pc_sel_e     w_pc_sel;
    logic        w_redirect;

    next_pc_logic u_next_pc (
        .pc           (r_pc),
        .id_pc4       (r_id_pc4),
        .id_valid     (r_id_valid),
        .branch_taken (branch_taken),
        .jump         (jump),
        .branch_imm   (branch_imm),
        .jump_index   (jump_index),
        .next_pc      (w_next_pc),
        .pc_sel       (w_pc_sel)
    );

    assign w_redirect = (w_pc_sel != PC_SEQ);

    // A redirect wins over stall and flush; no delay slot, so the fetch in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_id_instr    <= NOP_INSTR;
            r_id_pc4      <= 32'd0;
            r_id_valid    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (w_redirect) begin
            r_pc       <= w_next_pc;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                r_id_instr <= NOP_INSTR;
                r_id_valid <= 1'b0;
            end
        end else if (flush) begin
            r_pc       <= w_next_pc;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_next_pc;
            r_id_instr    <= imem_instr;
            r_id_pc4      <= w_next_pc;
            r_id_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc4      = r_id_pc4;
    assign id_valid    = r_id_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] fetch_count;

  // second instance for the reset-vector wrap case
  logic        rst_w;
  logic        zero_w;
  logic [15:0] zero16_w;
  logic [25:0] zero26_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_instr_w;
  logic [31:0] id_instr_w;
  logic [31:0] id_pc4_w;
  logic        id_valid_w;
  logic [31:0] fetch_count_w;

  int n_checks;
  int n_pass;
  logic chk_en;

  logic [31:0] mem_arr [0:63];

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_count;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .rst          (rst_w),
    .stall        (zero_w),
    .flush        (zero_w),
    .branch_taken (zero_w),
    .branch_imm   (zero16_w),
    .jump         (zero_w),
    .jump_index   (zero26_w),
    .imem_addr    (imem_addr_w),
    .imem_instr   (imem_instr_w),
    .id_instr     (id_instr_w),
    .id_pc4       (id_pc4_w),
    .id_valid     (id_valid_w),
    .fetch_count  (fetch_count_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:8] == 24'd0) return mem_arr[addr[7:2]];
    return {addr[31:2], 2'b01} ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign imem_instr_w = 32'h1234_5678;

  // behavioural reference: one instruction-fetch step per rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
      m_pc4   <= 32'h0;
      m_valid <= 1'b0;
      m_count <= 32'h0;
    end else begin
      int off;
      logic [31:0] tgt;
      off = int'($signed(branch_imm));
      if (m_valid && jump) tgt = {m_pc4[31:28], jump_index, 2'b00};
      else                 tgt = m_pc4 + 32'(off * 4);
      if (m_valid && (jump || branch_taken)) begin
        m_pc    <= tgt;
        m_valid <= 1'b0;
        m_instr <= 32'h0;
      end else if (stall) begin
        if (flush) begin
          m_valid <= 1'b0;
          m_instr <= 32'h0;
        end
      end else if (flush) begin
        m_pc    <= m_pc + 32'd4;
        m_valid <= 1'b0;
        m_instr <= 32'h0;
      end else begin
        m_pc    <= m_pc + 32'd4;
        m_instr <= mem_word(m_pc);
        m_pc4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_count <= m_count + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // scoreboard compare, every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imem_addr",   imem_addr,          m_pc);
      chk("m_id_instr",    id_instr,           m_instr);
      chk("m_id_pc4",      id_pc4,             m_pc4);
      chk("m_id_valid",    {31'd0, id_valid},  {31'd0, m_valid});
      chk("m_fetch_count", fetch_count,        m_count);
    end
  end

  // driver tasks
  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_imm = 16'h0; jump_index = 26'h0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    rst_w    = 1'b1;
    zero_w   = 1'b0;
    zero16_w = 16'h0;
    zero26_w = 26'h0;
    idle_inputs();
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h0001_0020;
    mem_arr[1] = 32'h8C01_0004;
    mem_arr[2] = 32'hAC22_0000;
    #1 chk_en = 1'b1;

    // reset values
    edges(0);
    chk("rst_addr",  imem_addr,   32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    #1 rst = 1'b0;

    // sequential fetch
    edges(1);
    chk("seq_pc4_1",   id_pc4,   32'h4);
    chk("seq_instr_1", id_instr, 32'h0001_0020);
    edges(1);
    chk("seq_pc4_2",   id_pc4,   32'h8);
    chk("seq_instr_2", id_instr, 32'h8C01_0004);
    edges(1);
    chk("seq_pc4_3",   id_pc4,   32'hC);
    chk("seq_instr_3", id_instr, 32'hAC22_0000);
    chk("seq_valid",   {31'd0, id_valid}, 32'h1);
    chk("seq_count",   fetch_count, 32'd3);
    chk("seq_addr",    imem_addr,   32'hC);

    // async reset mid-cycle, no edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr",  imem_addr,   32'h0);
    chk("arst_valid", {31'd0, id_valid}, 32'h0);
    chk("arst_instr", id_instr,    32'h0);
    chk("arst_count", fetch_count, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    // branch forward
    edges(4);
    chk("br_pre_pc4", id_pc4, 32'h10);
    branch_taken = 1'b1; branch_imm = 16'h0004;
    edges(1);
    chk("br_fwd_addr",  imem_addr, 32'h20);
    chk("br_fwd_valid", {31'd0, id_valid}, 32'h0);
    chk("br_fwd_count", fetch_count, 32'd4);
    idle_inputs();

    // branch backward
    do_reset();
    edges(4);
    branch_taken = 1'b1; branch_imm = 16'hFFFF;
    edges(1);
    chk("br_bwd_addr", imem_addr, 32'hC);
    idle_inputs();

    // jump beats branch; ignored while id_valid is low
    do_reset();
    edges(5);
    chk("jp_pre_pc4", id_pc4, 32'h14);
    jump = 1'b1; jump_index = 26'h0; branch_taken = 1'b1; branch_imm = 16'h0040;
    edges(1);
    chk("jp_addr",  imem_addr, 32'h0);
    chk("jp_valid", {31'd0, id_valid}, 32'h0);
    edges(1);
    chk("jp_novalid_addr",  imem_addr, 32'h4);
    chk("jp_novalid_valid", {31'd0, id_valid}, 32'h1);
    idle_inputs();

    // stall, stall+flush, stall+branch
    do_reset();
    edges(3);
    stall = 1'b1;
    edges(2);
    chk("st_addr",  imem_addr,   32'hC);
    chk("st_pc4",   id_pc4,      32'hC);
    chk("st_count", fetch_count, 32'd3);
    chk("st_instr", id_instr,    32'hAC22_0000);
    flush = 1'b1;
    edges(1);
    chk("stfl_valid", {31'd0, id_valid}, 32'h0);
    chk("stfl_addr",  imem_addr, 32'hC);
    chk("stfl_instr", id_instr,  32'h0);
    idle_inputs();
    edges(1);
    chk("unst_pc4", id_pc4, 32'h10);
    stall = 1'b1; branch_taken = 1'b1; branch_imm = 16'h0002;
    edges(1);
    chk("stbr_addr",  imem_addr, 32'h18);
    chk("stbr_valid", {31'd0, id_valid}, 32'h0);
    idle_inputs();

    // reset vector wrap
    chk("wrap_rst_addr", imem_addr_w, 32'hFFFF_FFFC);
    rst_w = 1'b0;
    edges(1);
    chk("wrap_addr", imem_addr_w, 32'h0);
    chk("wrap_pc4",  id_pc4_w,    32'h0);
    chk("wrap_instr", id_instr_w, 32'h1234_5678);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom_range(0, 9) < 2);
      flush        = ($urandom_range(0, 9) < 1);
      branch_taken = ($urandom_range(0, 9) < 2);
      jump         = ($urandom_range(0, 19) < 1);
      branch_imm   = 16'($urandom);
      jump_index   = 26'($urandom_range(0, 80));
      if ($urandom_range(0, 9) == 0) jump_index = 26'($urandom);
      edges(1);
    end
    idle_inputs();
    edges(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS core. It owns the program counter and drives the address of the combinational instruction memory. It latches the returned instruction into an IF/ID pipeline register for the decoder. It also computes the next PC from sequential, branch and jump requests that the ID stage resolves, and handles stall and flush.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hold the PC and the IF/ID register.
- `flush`  in  1  squash the IF/ID register contents.
- `branch_taken`  in  1  the ID-stage branch resolved as taken.
- `branch_imm`  in  16  raw branch immediate, a signed word offset.
- `jump`  in  1  the ID-stage instruction is a J-type jump.
- `jump_index`  in  26  J-type target field.
- `imem_addr`  out  32  current PC, sent to the instruction memory as a byte address.
- `imem_instr`  in  32  instruction returned combinationally for `imem_addr`.
- `id_instr`  out  32  IF/ID instruction register.
- `id_pc4`  out  32  IF/ID register holding PC+4 of `id_instr`.
- `id_valid`  out  1  IF/ID contents are a real instruction.
- `fetch_count`  out  32  count of instructions accepted into IF/ID.

## Operation
- Reset values (asynchronous, visible immediately):
  - `pc` = `RESET_PC`
  - `id_instr` = 0 (NOP)
  - `id_pc4` = 0
  - `id_valid` = 0
  - `fetch_count` = 0
- `imem_addr` is a direct copy of `pc`, with no added latency.
- Redirect condition: `redirect = id_valid & (jump | branch_taken)`. When `id_valid` = 0, `jump` and `branch_taken` are ignored.
- Target arithmetic, all modulo 2^32:
  - Branch target = `id_pc4` + (sign_extend(`branch_imm`) << 2).
  - Jump target = {`id_pc4`[31:28], `jump_index`, 2'b00}.
  - If `jump` and `branch_taken` are both asserted, `jump` wins.
- Per-edge priority, highest first:
  1. `redirect`: `pc` <= target; `id_valid` <= 0; `id_instr` <= 0; `id_pc4` unchanged; `fetch_count` unchanged. Redirect overrides `stall` and `flush`. There is no delay slot: the instruction fetched in the redirect cycle is discarded.
  2. `stall`: `pc` holds; IF/ID holds, except that `flush` still clears `id_valid` and `id_instr`.
  3. `flush`: `pc` <= `pc`+4; `id_valid` <= 0; `id_instr` <= 0; the fetched instruction is discarded; the count does not increment.
  4. Otherwise: `pc` <= `pc`+4; `id_instr` <= `imem_instr`; `id_pc4` <= `pc`+4; `id_valid` <= 1; `fetch_count` <= `fetch_count`+1.
- PC wrap: 32'hFFFF_FFFC + 4 = 0. `fetch_count` wraps at 2^32.
- Reset during a stall or redirect overrides everything, at any time.

## Timing
- Fetch latency is one cycle: the instruction at `imem_addr` in cycle n appears on `id_instr` in cycle n+1.
- Redirect penalty is one bubble. The target is on `imem_addr` in the cycle after the edge on which `redirect` was sampled, and `id_valid` is 0 during that cycle.
- `stall`, `flush`, `branch_taken` and `jump` are sampled only at the rising edge. No output depends combinationally on them; only `imem_addr` tracks `pc`.
- After reset deasserts, the first edge loads instruction word `RESET_PC`>>2 into IF/ID.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0000
  - `PC_STEP` = 4
  - the default reset vector constant
  - next-PC select encoding `PC_SEQ`, `PC_BRANCH`, `PC_JUMP` (2-bit enum)
- One combinational sub-module, `next_pc_logic`:
  - inputs: `pc`, `id_pc4`, `redirect` controls, `branch_imm`, `jump_index`
  - outputs: next-PC value and select
- The top level holds the PC register, IF/ID register and counter.

## Test plan
- **Async reset:** assert `rst` mid-run with no clock edge. Required immediately: `imem_addr`=0, `id_valid`=0, `id_instr`=0, `fetch_count`=0.
- **Sequential fetch:** memory returns 32'h00010020, 32'h8C010004, 32'hAC220000 over three edges. Required: `id_pc4` = 4, 8, 12; `id_valid`=1; `fetch_count`=3; `imem_addr`=12.
- **Branch redirect:**
  - With `id_pc4`=0x10, `branch_imm`=0x0004 and `branch_taken`=1: required next `imem_addr`=0x20 with `id_valid`=0.
  - Repeat with `branch_imm`=0xFFFF: required next `imem_addr`=0x0C.
- **Jump priority:** with `id_pc4`=0x14, `jump`=1, `jump_index`=0 and `branch_taken`=1 together: required `imem_addr`=0x0 and one bubble. With `id_valid`=0, the same inputs give sequential `pc`+4.
- **Stall and flush:**
  - Hold `stall` for 2 edges: `pc`, `id_*` and `fetch_count` are unchanged.
  - `stall`+`flush`: `id_valid`=0, `pc` held.
  - `stall`+`branch_taken` (with `id_valid`=1): redirect occurs.
- **Wrap:** with `RESET_PC`=32'hFFFF_FFFC, after one edge `imem_addr`=0 and `id_pc4`=0.
